// File: rtl/fifo_stream_reader_pkg.sv
// fifo_stream_reader_pkg: shared constants and FSM encoding for the FIFO stream reader
// Contents: skid depth, occupancy width, read-issue FSM state type.
package fifo_stream_reader_pkg;
    localparam int FSR_SKID_DEPTH = 3;
    localparam int FSR_OCC_W      = 2;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        STALL = 2'd2,
        DRAIN = 2'd3
    } fsr_state_e;
endpackage

// File: rtl/fsr_skid_buf.sv
// fsr_skid_buf: 3-entry register FIFO absorbing the FIFO read latency
// Ports: clk, rst (sync active-high), push/din write side, pop/head read side, occ entry count.
module fsr_skid_buf
    import fifo_stream_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head,
    output logic [FSR_OCC_W-1:0]  occ
);
    logic [DATA_WIDTH-1:0] mem [FSR_SKID_DEPTH];
    logic [FSR_OCC_W-1:0]  wr_idx;
    // entry 0 is always the head; a simultaneous pop shifts the write slot down by one
    assign wr_idx = pop ? occ - FSR_OCC_W'(1) : occ;
    assign head   = mem[0];
    always_ff @(posedge clk) begin
        if (rst) begin
            occ <= '0;
            for (int i = 0; i < FSR_SKID_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (pop) for (int i = 0; i < FSR_SKID_DEPTH - 1; i++) mem[i] <= mem[i+1];
            if (push) mem[wr_idx] <= din;
            occ <= occ + FSR_OCC_W'(push) - FSR_OCC_W'(pop);
        end
    end
endmodule

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: turns a 1-cycle-latency FIFO read port into a framed valid/ready stream
// Ports: clk, rst (sync active-high), enable, fifo_empty/fifo_data/fifo_rd_en (FIFO read port),
//        m_valid/m_ready/m_data/m_last (output stream), word_count (only with FSR_COUNT_EN).
// Build option FSR_COUNT_EN adds the CNT_WIDTH parameter and the word_count handshake counter.
module fifo_stream_reader
    import fifo_stream_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int BURST_LEN  = 4
`ifdef FSR_COUNT_EN
    , parameter int CNT_WIDTH = 16
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last
`ifdef FSR_COUNT_EN
    , output logic [CNT_WIDTH-1:0] word_count
`endif
);
    localparam int BW = BURST_LEN > 1 ? $clog2(BURST_LEN) : 1;
    logic [FSR_OCC_W-1:0] occ;
    logic [FSR_OCC_W:0]   lvl_d;
    logic                 inflight, hs;
    logic [BW-1:0]        bidx;
    fsr_state_e           state, state_d;
    fsr_skid_buf #(.DATA_WIDTH(DATA_WIDTH)) u_buf (
        .clk  (clk),
        .rst  (rst),
        .push (inflight),
        .din  (fifo_data),
        .pop  (hs),
        .head (m_data),
        .occ  (occ)
    );
    assign m_valid    = occ != '0;
    assign hs         = m_valid & m_ready;
    assign m_last     = m_valid & (bidx == BW'(BURST_LEN - 1));
    // STALL is exactly "buffered + in-flight words fill the skid buffer", so m_ready never reaches rd_en
    assign fifo_rd_en = ~rst & enable & ~fifo_empty & (state != STALL);
    always_comb begin
        lvl_d   = {1'b0, occ} + {2'b0, inflight} - {2'b0, hs} + {2'b0, fifo_rd_en};
        state_d = lvl_d == (FSR_OCC_W+1)'(FSR_SKID_DEPTH) ? STALL :
                  fifo_rd_en                              ? FILL  :
                  lvl_d == '0                             ? IDLE  : DRAIN;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            inflight <= 1'b0;
            bidx     <= '0;
        end else begin
            state    <= state_d;
            inflight <= fifo_rd_en;
            if (hs) bidx <= m_last ? '0 : bidx + BW'(1);
        end
    end
`ifdef FSR_COUNT_EN
    always_ff @(posedge clk) begin
        if (rst) word_count <= '0;
        else if (hs) word_count <= word_count + CNT_WIDTH'(1);
    end
`endif
endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: scoreboard bench with a queue-based FIFO model and directed + random stimulus
module tb_fifo_stream_reader;
    localparam int BL = 4;
    typedef struct {
        logic [7:0] d;
        logic       l;
    } exp_t;
    logic       clk = 1'b0, rst = 1'b1, enable = 1'b0, m_ready = 1'b0;
    logic       fifo_empty = 1'b1;
    logic [7:0] fifo_data = '0;
    logic       fifo_rd_en, m_valid, m_last;
    logic [7:0] m_data;
`ifdef FSR_COUNT_EN
    logic [15:0] word_count;
`endif
    logic [7:0] fifo_q [$];
    exp_t       exp_q [$];
    exp_t       e;
    int         wr_n = 0, outstanding = 0, hs_total = 0, checks = 0, errors = 0, cyc = 0;
    logic       prev_v = 1'b0, prev_hs = 1'b0, prev_l = 1'b0;
    logic [7:0] prev_d = '0;

    always #5 clk = ~clk;

    fifo_stream_reader #(.DATA_WIDTH(8), .BURST_LEN(BL)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_en (fifo_rd_en),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last)
`ifdef FSR_COUNT_EN
        , .word_count (word_count)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, expv, cyc);
        end
    endtask

    // a written word will be the wr_n-th word delivered, so its framing is known at write time
    task automatic push_word(input logic [7:0] d);
        fifo_q.push_back(d);
        exp_q.push_back('{d: d, l: (wr_n % BL) == BL - 1});
        wr_n++;
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b1; enable = 1'b0; m_ready = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic wait_valid();
        int n = 0;
        do begin @(negedge clk); n++; end while (!m_valid && n < 50);
        if (!m_valid) chk("valid_timeout", 0, 1);
    endtask

    // synchronous FIFO model: registered read data, empty flag updated at the edge
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            fifo_q.delete();
            exp_q.delete();
            wr_n        = 0;
            outstanding = 0;
            fifo_data  <= '0;
            fifo_empty <= 1'b1;
        end else begin
            if (fifo_rd_en) begin
                chk("rd_bound", 32'(outstanding < 3), 1);
                fifo_data <= fifo_q.pop_front();
            end
            outstanding += int'(fifo_rd_en) - int'(m_valid && m_ready);
            fifo_empty <= fifo_q.size() == 0;
        end
    end

    // monitor: ordering, framing and hold-until-accepted
    always @(negedge clk) begin
        if (rst) begin
            prev_v   = 1'b0;
            prev_hs  = 1'b0;
            hs_total = 0;
        end else begin
            if (prev_v && !prev_hs) begin
                chk("hold_valid", 32'(m_valid), 1);
                chk("hold_data", 32'(m_data), 32'(prev_d));
                chk("hold_last", 32'(m_last), 32'(prev_l));
            end
            if (!m_valid) chk("last_idle", 32'(m_last), 0);
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) chk("spurious_word", 32'(m_data), 32'hFFFF_FFFF);
                else begin
                    e = exp_q.pop_front();
                    chk("data", 32'(m_data), 32'(e.d));
                    chk("last", 32'(m_last), 32'(e.l));
                end
                hs_total++;
            end
            prev_v  = m_valid;
            prev_hs = m_valid && m_ready;
            prev_d  = m_data;
            prev_l  = m_last;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, n;
        // reset state
        @(negedge clk);
        chk("rst_valid", 32'(m_valid), 0);
        chk("rst_rd_en", 32'(fifo_rd_en), 0);
        chk("rst_data", 32'(m_data), 0);
        chk("rst_last", 32'(m_last), 0);

        // three words: first-word latency and back-to-back delivery
        do_reset();
        enable = 1'b1; m_ready = 1'b1;
        push_word(8'h11); push_word(8'h22); push_word(8'h33);
        n = 0;
        do begin @(negedge clk); n++; end while (fifo_empty && n < 20);
        c0 = cyc;
        wait_valid();
        chk("first_latency", 32'(cyc - c0), 2);
        repeat (2) @(negedge clk);
        @(posedge clk);
        chk("three_hs", 32'(hs_total), 3);

        // eight words, burst framing on 0x03 and 0x07
        do_reset();
        enable = 1'b1; m_ready = 1'b1;
        for (int i = 0; i < 8; i++) push_word(8'(i));
        wait_valid();
        repeat (7) @(negedge clk);
        @(posedge clk);
        chk("eight_hs", 32'(hs_total), 8);

        // backpressure: only three reads outstanding, then gapless release
        do_reset();
        enable = 1'b1; m_ready = 1'b0;
        for (int i = 0; i < 6; i++) push_word(8'(i));
        n = 0;
        repeat (12) begin @(negedge clk); n += int'(fifo_rd_en); end
        chk("stall_reads", 32'(n), 3);
        chk("stall_data", 32'(m_data), 0);
        @(posedge clk); #1 m_ready = 1'b1;
        repeat (6) @(negedge clk);
        @(posedge clk);
        chk("release_hs", 32'(hs_total), 6);

        // enable dropped after two reads
        do_reset();
        enable = 1'b1; m_ready = 1'b1;
        for (int i = 0; i < 5; i++) push_word(8'(8'h40 + i));
        n = 0;
        c0 = 0;
        while (n < 2 && c0 < 20) begin @(negedge clk); c0++; n += int'(fifo_rd_en); end
        @(posedge clk); #1 enable = 1'b0;
        n = 0;
        repeat (10) begin @(negedge clk); n += int'(fifo_rd_en); end
        chk("no_third_read", 32'(n), 0);
        chk("enable_hs", 32'(hs_total), 2);
        chk("enable_drained", 32'(m_valid), 0);
        @(posedge clk); #1 enable = 1'b1;
        repeat (10) @(negedge clk);

        // reset with a full skid buffer and a non-zero burst index
        do_reset();
        enable = 1'b1; m_ready = 1'b0;
        for (int i = 0; i < 5; i++) push_word(8'(8'h60 + i));
        wait_valid();
        @(posedge clk); #1 m_ready = 1'b1;
        @(posedge clk); #1 m_ready = 1'b0;
        repeat (6) @(negedge clk);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_valid", 32'(m_valid), 0);
`ifdef FSR_COUNT_EN
        chk("midrst_count", 32'(word_count), 0);
`endif
        push_word(8'hA5);
        for (int i = 0; i < 3; i++) push_word(8'(8'hB0 + i));
        wait_valid();
        chk("refill_first", 32'(m_data), 32'hA5);
        @(posedge clk); #1 m_ready = 1'b1;
        repeat (10) @(negedge clk);
        chk("refill_hs", 32'(hs_total), 4);

        // randomized traffic
        do_reset();
        repeat (1500) begin
            @(posedge clk); #1;
            m_ready = $urandom_range(0, 3) != 0;
            enable  = $urandom_range(0, 7) != 0;
            if ($urandom_range(0, 2) != 0 && fifo_q.size() < 12) push_word(8'($urandom_range(0, 255)));
        end
        enable = 1'b1; m_ready = 1'b1;
        n = 0;
        while ((exp_q.size() != 0 || m_valid) && n < 100) begin @(negedge clk); n++; end
        chk("drain_empty", 32'(exp_q.size()), 0);
        chk("drain_valid", 32'(m_valid), 0);
`ifdef FSR_COUNT_EN
        chk("word_count", 32'(word_count), 32'(hs_total[15:0]));
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
